// File: rtl/ram_write_sequencer.sv
// ram_write_sequencer: RAM write-port master with a request FIFO and a pattern fill engine
module ram_write_sequencer #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [ADDR_W-1:0]               req_addr,
    input  logic [DATA_W-1:0]               req_data,
    input  logic                            fill_start,
    input  logic [1:0]                      fill_mode,
    input  logic [DATA_W-1:0]               fill_seed,
    output logic                            busy,
    output logic                            done,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            wr_en,
    output logic [ADDR_W-1:0]               wr_addr,
    output logic [DATA_W-1:0]               wr_data
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, FILL} state_t;

    state_t                     state_q, state_d;
    logic [ADDR_W-1:0]          cnt_q, cnt_d;
    logic [1:0]                 mode_q, mode_d;
    logic [DATA_W-1:0]          seed_q, seed_d;
    logic                       wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]          wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]          wr_data_q, wr_data_d;
    logic                       done_q, done_d;
    logic [ADDR_W+DATA_W-1:0]   mem_q [FIFO_DEPTH];
    logic [ADDR_W+DATA_W-1:0]   mem_d [FIFO_DEPTH];
    logic [PW-1:0]              rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]              count_q, count_d;
    logic                       full, push, pop;

    function automatic logic [DATA_W-1:0] pattern(input logic [1:0] mode,
                                                  input logic [DATA_W-1:0] seed,
                                                  input logic [ADDR_W-1:0] k);
        logic [DATA_W-1:0] kd;
        kd = DATA_W'(k);
        return mode == 2'd0 ? seed : mode == 2'd1 ? kd : mode == 2'd2 ? seed + kd : seed - kd;
    endfunction

    assign full       = count_q == CW'(FIFO_DEPTH);
    assign req_ready  = !full;
    assign push       = req_valid && !full;
    assign busy       = state_q == FILL;
    assign done       = done_q;
    assign fifo_count = count_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;

    // Sequencer: a fill command beats a FIFO pop in IDLE; FILL emits one word per cycle until the counter wraps
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        seed_d    = seed_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        pop       = 1'b0;
        if (state_q == IDLE) begin
            if (fill_start) begin
                state_d   = FILL;
                mode_d    = fill_mode;
                seed_d    = fill_seed;
                wr_en_d   = 1'b1;
                wr_addr_d = '0;
                wr_data_d = pattern(fill_mode, fill_seed, '0);
                cnt_d     = ADDR_W'(1);
            end else if (count_q != '0) begin
                pop                    = 1'b1;
                wr_en_d                = 1'b1;
                {wr_addr_d, wr_data_d} = mem_q[rd_ptr_q];
            end
        end else if (cnt_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = cnt_q;
            wr_data_d = pattern(mode_q, seed_q, cnt_q);
            cnt_d     = cnt_q + ADDR_W'(1);
        end
    end

    // Request FIFO bookkeeping; a refused push (full) is never stored even if a pop frees a slot
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = {req_addr, req_data};
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    // Control and write-port registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mode_q    <= '0;
            seed_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            seed_q    <= seed_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
        end
    end

    // FIFO storage needs no reset; pointers and count define validity
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end
endmodule

// File: doc/ram_write_sequencer.md
# ram_write_sequencer

Write-port master for the dual-port 32x4 RAM. The read side is driven by a free-running address counter; this block owns the write port. It accepts single-word write requests through a valid/ready handshake, buffers them in a 4-entry FIFO, and can also fill the whole RAM with a generated pattern on command. It sits between the board-input logic (switch/key capture) and the RAM's `data`/`wraddress`/`wren` pins, in the RAM's clock domain.

## Interface
- `ADDR_W`, 5, RAM address width; the fill covers 2^ADDR_W words.
- `DATA_W`, 4, RAM data width.
- `FIFO_DEPTH`, 4, request FIFO entries; must be a power of two.
- `clock`  in  1  RAM clock; all state updates on its rising edge.
- `reset`  in  1  reset, synchronous, active-high; clock clock.
- `req_valid`  in  1  single-write request present.
- `req_ready`  out  1  FIFO can accept; equals `!full`.
- `req_addr`  in  ADDR_W  request address.
- `req_data`  in  DATA_W  request data.
- `fill_start`  in  1  level-sampled fill command; ignored unless state is IDLE.
- `fill_mode`  in  2  pattern select, sampled with `fill_start`.
- `fill_seed`  in  DATA_W  pattern seed, sampled with `fill_start`.
- `busy`  out  1  high while state is FILL.
- `done`  out  1  one-cycle pulse at fill completion.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of queued requests.
- `wr_en`  out  1  RAM `wren`, registered.
- `wr_addr`  out  ADDR_W  RAM `wraddress`, registered.
- `wr_data`  out  DATA_W  RAM `data`, registered.

## Operation
- States: IDLE and FILL.
- **Push:** a request is pushed at any rising edge where `req_valid && req_ready`, in either state. The requester holds `req_valid`, `req_addr` and `req_data` until ready.
- **IDLE priority:** `fill_start` first, then a FIFO pop.
- **IDLE, `fill_start`=1:** latch `fill_mode` and `fill_seed`, go to FILL, emit word 0, and set the fill counter to 1. The FIFO is untouched.
- **IDLE, FIFO non-empty, no fill:** pop the head and register `wr_en`=1 with the head's addr/data. One pop per cycle, so a full FIFO drains in back-to-back cycles.
- **IDLE, otherwise:** `wr_en`=0. `wr_addr` and `wr_data` hold their last values.
- **FILL:** emit one word per cycle, k = 0 .. 2^ADDR_W-1, with `wr_addr`=k. All data arithmetic is mod 2^DATA_W, with k truncated to DATA_W bits:
  - mode 0: `fill_seed`
  - mode 1: k
  - mode 2: `fill_seed`+k
  - mode 3: `fill_seed`-k
- **Fill end:** on the edge after the last word is registered, set `wr_en`=0, pulse `done` for one cycle, and return to IDLE. The counter wraps to 0 and is not reused.
- **During FILL:** `fill_start` is ignored and no pops occur. Pushes continue while the FIFO is not full. Queued requests drain after the fill and therefore overwrite fill data.
- **Simultaneous push and pop:** `fifo_count` is unchanged. The FIFO head order is preserved (FIFO order, same address later wins).
- **Push blocked when full:** `req_ready` depends only on `full`. A push is refused when full even if a pop happens on the same edge.

## Timing
- **Reset values:** state IDLE, FIFO empty, `fifo_count`=0, `req_ready`=1, `busy`=0, `done`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0.
- **Request latency, empty FIFO and IDLE:**
  - Accepted at edge N.
  - Popped at edge N+1; `wr_en`/`wr_addr`/`wr_data` valid from N+1 to N+2.
  - RAM captures at edge N+2.
- **Fill timing:** `fill_start` is sampled at edge N.
  - Word k is on the bus during the cycle after edge N+k, for k = 0..31.
  - `busy`=1 from edge N to edge N+32.
  - At edge N+32: `done`=1 and `wr_en`=0. At N+33: `done`=0.
  - The first FIFO pop can occur at N+33.
- **Reset mid-fill or mid-drain:** the next edge returns to reset values. The FIFO is cleared, no `done` pulse is emitted, and a partial fill is left in RAM.
- `busy` and `req_ready` are combinational from registered state.

## Test plan
- **Reset, then single request:** reset 2 cycles, push addr 7 / data 0xA at edge N. Required: `wr_en`=1, `wr_addr`=7, `wr_data`=0xA exactly between N+1 and N+2, then `wr_en`=0. Read port at addr 7 returns 0xA.
- **Burst:** hold `req_valid` with addrs 0..5 while the FIFO stays empty. Required: writes appear on consecutive cycles in order, `fifo_count` never exceeds 1, and `req_ready` stays 1.
- **Fill mode 3, seed 14:** required 32 consecutive writes with `wr_data` = (14-k) mod 16, `busy` high for exactly 32 cycles, and `done` pulsed once at N+32. RAM readback over 0..31 matches.
- **Push during fill:** start fill mode 0 seed 0x3, then push 5 requests. Required: `req_ready` drops after 4 accepts and `fifo_count`=4. After `done`, the 4 writes drain on 4 consecutive cycles, and the 5th request is accepted when `req_ready` returns.
- **Simultaneous `fill_start` and non-empty FIFO in IDLE:** required: the fill runs first, `fifo_count` is unchanged during the fill, and queued writes follow at N+33.
- **Reset at fill word 10:** required: `wr_en`=0 and `busy`=0 on the next edge, no `done`, `fifo_count`=0, and a new `fill_start` restarts at addr 0.
